// File: rtl/dsc_mul_scheduler.sv
// dsc_mul_scheduler: round-robin arbiter sharing one dsc_serial_mul among NUM_REQ requesters,
// with a watchdog that turns a run which never reports done into an error response.
module dsc_mul_scheduler #(
    parameter int DATA_WIDTH     = 5,
    parameter int NUM_INPUTS     = 2,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 2**(DATA_WIDTH*NUM_INPUTS) + 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0]  req_data,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [ID_W-1:0]                           resp_id,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]          resp_data,
    output logic                                      resp_err,
    output logic                                      mul_rst,
    output logic                                      mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]          mul_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]          mul_data_out,
    input  logic                                      mul_done,
    output logic                                      busy
);
    localparam int OW   = NUM_INPUTS*DATA_WIDTH;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [WD_W-1:0] r_wd;
    logic            r_mul_rst;
    logic            r_mul_en;
    logic [OW-1:0]   r_mul_data;
    logic            r_resp_valid;
    logic [OW-1:0]   r_resp_data;
    logic            r_resp_err;
    logic            w_gv;
    logic [ID_W-1:0] w_gid;
    logic [ID_W:0]   w_s;
    logic [OW-1:0]   w_ops [NUM_REQ];

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_ops
            assign w_ops[g] = req_data[g*OW +: OW];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest valid at/after the pointer wins.
    always_comb begin
        w_gv  = 1'b0;
        w_gid = '0;
        w_s   = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            w_s = {1'b0, r_ptr} + (ID_W+1)'(k);
            w_s = (w_s >= (ID_W+1)'(NUM_REQ)) ? w_s - (ID_W+1)'(NUM_REQ) : w_s;
            if (req_valid[w_s[ID_W-1:0]]) begin
                w_gv  = 1'b1;
                w_gid = w_s[ID_W-1:0];
            end
        end
    end

    // Gated by rst so the grant also drops immediately on an asynchronous reset.
    assign req_ready   = (r_state == S_IDLE && w_gv && !rst) ? NUM_REQ'(1) << w_gid : '0;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_id;
    assign resp_data   = r_resp_data;
    assign resp_err    = r_resp_err;
    assign mul_rst     = r_mul_rst;
    assign mul_en      = r_mul_en;
    assign mul_data_in = r_mul_data;
    assign busy        = r_state != S_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_wd         <= '0;
            r_mul_rst    <= 1'b0;
            r_mul_en     <= 1'b0;
            r_mul_data   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gv) begin
                        r_mul_data <= w_ops[w_gid];
                        r_id       <= w_gid;
                        r_ptr      <= (w_gid == ID_W'(NUM_REQ-1)) ? '0 : w_gid + ID_W'(1);
                        r_mul_rst  <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_mul_rst <= 1'b0;
                    r_mul_en  <= 1'b1;
                    r_wd      <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    r_wd <= r_wd + WD_W'(1);
                    if (mul_done || r_wd == WD_W'(TIMEOUT_CYCLES-1)) begin
                        r_resp_data  <= mul_done ? mul_data_out : '0;
                        r_resp_err   <= !mul_done;
                        r_mul_en     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_wd         <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsc_mul_scheduler.sv
// tb_dsc_mul_scheduler: randomized scenario bench for dsc_mul_scheduler against a stub
// multiplier whose done latency (in en cycles) is chosen per transaction; 0 means never done.
module tb_dsc_mul_scheduler;
    localparam int TO = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [39:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [9:0]  resp_data;
    logic        resp_err;
    logic        mul_rst;
    logic        mul_en;
    logic [9:0]  mul_data_in;
    logic [9:0]  mul_data_out;
    logic        mul_done;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_ptr  = 0;
    int stub_lat = 0;
    logic [7:0] stub_cnt;

    dsc_mul_scheduler #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .mul_rst(mul_rst), .mul_en(mul_en), .mul_data_in(mul_data_in),
        .mul_data_out(mul_data_out), .mul_done(mul_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stub_cnt <= '0;
        else if (mul_rst) stub_cnt <= '0;
        else if (mul_en) stub_cnt <= stub_cnt + 8'd1;
    end
    assign mul_done     = mul_en && stub_lat != 0 && int'(stub_cnt) == stub_lat - 1;
    assign mul_data_out = mul_data_in[4:0] * mul_data_in[9:5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_grant(input logic [3:0] vm);
        for (int k = 0; k < 4; k++)
            if (vm[(rr_ptr + k) % 4]) return (rr_ptr + k) % 4;
        return -1;
    endfunction

    task automatic txn(input logic [3:0] vm, input int lat, input int hold, input bit use_ops,
                       input logic [9:0] ops_in);
        int g, en_n, cyc, exp_en;
        logic [39:0] rd;
        logic [9:0] ops, exp_d;
        logic [3:0] oh;
        logic exp_e;
        bit bad;
        g = exp_grant(vm);
        rd[31:0]  = $urandom;
        rd[39:32] = 8'($urandom);
        if (use_ops) rd[g*10 +: 10] = ops_in;
        ops = rd[g*10 +: 10];
        stub_lat  = lat;
        req_data  = rd;
        req_valid = vm;
        #1;
        oh = 4'b0001 << g;
        n_tests++;
        if (req_ready !== oh) begin n_fail++; $display("FAIL grant: req_ready=%b expected %b", req_ready, oh); end
        tick();
        req_valid = '0;
        rr_ptr = (g + 1) % 4;
        n_tests++;
        if ({mul_rst, mul_en, busy, mul_data_in} !== {1'b1, 1'b0, 1'b1, ops}) begin
            n_fail++;
            $display("FAIL clear: rst=%b en=%b busy=%b data=%h expected 1 0 1 %h", mul_rst, mul_en, busy, mul_data_in, ops);
        end
        tick();
        en_n = 0; cyc = 0; bad = 0;
        while (resp_valid !== 1'b1 && cyc < 100) begin
            if (mul_en === 1'b1) en_n++;
            if (mul_rst !== 1'b0 || mul_data_in !== ops || req_ready !== 4'b0) bad = 1;
            tick();
            cyc++;
        end
        exp_e  = (lat == 0 || lat > TO);
        exp_en = exp_e ? TO : lat;
        exp_d  = exp_e ? 10'd0 : ops[4:0] * ops[9:5];
        n_tests++;
        if (en_n != exp_en || cyc != exp_en) begin
            n_fail++;
            $display("FAIL run_len: en cycles=%0d resp after %0d expected %0d", en_n, cyc, exp_en);
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL run_stable: operands/rst/ready disturbed during run, got 1 expected 0"); end
        n_tests++;
        if ({resp_id, resp_data, resp_err, mul_en} !== {2'(g), exp_d, exp_e, 1'b0}) begin
            n_fail++;
            $display("FAIL resp: id=%0d data=%0d err=%b en=%b expected %0d %0d %b 0", resp_id, resp_data, resp_err, mul_en, g, exp_d, exp_e);
        end
        bad = 0;
        req_valid = vm;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_data !== exp_d || resp_id !== 2'(g) || resp_err !== exp_e || req_ready !== 4'b0) bad = 1;
        end
        if (hold > 0) begin
            n_tests++;
            if (bad) begin n_fail++; $display("FAIL backpressure: response changed or grant issued while held, got 1 expected 0"); end
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake: resp_valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
        req_valid = vm;
        #1;
        oh = 4'b0001 << exp_grant(vm);
        n_tests++;
        if (req_ready !== oh) begin n_fail++; $display("FAIL rearb: req_ready=%b expected %b", req_ready, oh); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; resp_ready = 1'b0; req_data = 40'h12345_6789A;
        tick(); tick();
        n_tests++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: req_ready=%b expected 0000", req_ready); end
        n_tests++;
        if ({resp_valid, resp_id, resp_data, resp_err, mul_rst, mul_en, mul_data_in, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: valid=%b id=%0d data=%h err=%b mrst=%b en=%b din=%h busy=%b expected all 0",
                     resp_valid, resp_id, resp_data, resp_err, mul_rst, mul_en, mul_data_in, busy);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++;
        if (req_ready !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_none: req_ready=%b busy=%b expected 0000 0", req_ready, busy);
        end
        req_valid = 4'b1000;
        #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant: req_ready=%b expected 1000", req_ready); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_fairness();
        int q[$];
        int got[$];
        int ri, cyc, id;
        bit hs_prev;
        logic [9:0] ops [4];
        logic [9:0] exp_d;
        stub_lat = 3;
        for (int i = 0; i < 4; i++) ops[i] = 10'($urandom);
        req_data   = {ops[3], ops[2], ops[1], ops[0]};
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        #1;
        ri = 0; cyc = 0; hs_prev = 0;
        while (ri < 5 && cyc < 300) begin
            if (hs_prev) begin
                n_tests++;
                if (req_ready === 4'b0) begin n_fail++; $display("FAIL fair_rearb: req_ready=0000 expected a grant after handshake"); end
            end
            if (req_ready !== 4'b0) begin
                n_tests++;
                if (req_ready !== (4'b0001 << rr_ptr)) begin
                    n_fail++;
                    $display("FAIL fair_grant: req_ready=%b expected %b", req_ready, 4'b0001 << rr_ptr);
                end
                q.push_back(rr_ptr);
                got.push_back(rr_ptr);
                rr_ptr = (rr_ptr + 1) % 4;
            end
            hs_prev = resp_valid;
            if (resp_valid === 1'b1) begin
                id = (q.size() > 0) ? q.pop_front() : -1;
                exp_d = (id >= 0) ? ops[id][4:0] * ops[id][9:5] : 10'd0;
                n_tests++;
                if (int'(resp_id) != id || resp_data !== exp_d || resp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fair_resp: id=%0d data=%0d err=%b expected %0d %0d 0", resp_id, resp_data, resp_err, id, exp_d);
                end
                ri++;
            end
            tick();
            cyc++;
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        n_tests++;
        if (ri < 5) begin n_fail++; $display("FAIL fair_timeout: responses=%0d expected 5", ri); end
        for (int i = 0; i < got.size(); i++) begin
            n_tests++;
            if (got[i] != i % 4) begin n_fail++; $display("FAIL fair_order: grant %0d was %0d expected %0d", i, got[i], i % 4); end
        end
        tick();
    endtask

    task automatic test_single();
        txn(4'b0100, 10, 0, 1'b1, {5'd16, 5'd8});
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            txn(4'($urandom_range(1, 15)), $urandom_range(1, 11), $urandom_range(0, 3), 1'b0, 10'd0);
    endtask

    task automatic test_backpressure();
        txn(4'b0101, 4, 20, 1'b0, 10'd0);
    endtask

    task automatic test_timeout();
        txn(4'b0010, 0, 1, 1'b0, 10'd0);
        txn(4'b1001, TO, 0, 1'b0, 10'd0);
        txn(4'b0110, TO + 1, 0, 1'b0, 10'd0);
        txn(4'b1111, 5, 0, 1'b0, 10'd0);
    endtask

    task automatic test_async_reset();
        bit bad;
        stub_lat  = 0;
        req_data  = 40'hA5A5A_5A5A5;
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        n_tests++;
        if (mul_en !== 1'b1) begin n_fail++; $display("FAIL ar_running: mul_en=%b expected 1", mul_en); end
        req_valid = 4'b1111;
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({req_ready, resp_valid, resp_id, resp_data, resp_err, mul_rst, mul_en, mul_data_in, busy} !== '0) begin
            n_fail++;
            $display("FAIL ar_outs: ready=%b valid=%b en=%b din=%h busy=%b expected all 0", req_ready, resp_valid, mul_en, mul_data_in, busy);
        end
        rr_ptr = 0;
        bad = 0;
        repeat (3) begin tick(); if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1; end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin tick(); if (resp_valid !== 1'b0 || busy !== 1'b0) bad = 1; end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL ar_noresp: response or activity after reset, got 1 expected 0"); end
        txn(4'b1111, 4, 0, 1'b0, 10'd0);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dsc_mul_scheduler.md
Name: dsc_mul_scheduler

Overview:
Round-robin scheduler that shares one dsc_serial_mul instance among NUM_REQ requesters. It accepts one operand set from a requester and clears the multiplier. It then holds the operands and drives en until the multiplier reports done, and returns the product tagged with the requester id. A watchdog aborts runs that never complete, so a stuck datapath cannot deadlock the requesters.

Parameters:
DATA_WIDTH, 5, bits per operand; matches dsc_serial_mul.
NUM_INPUTS, 2, operands per multiply; matches dsc_serial_mul.
NUM_REQ, 4, number of requesters (>=2).
ID_W, 2, requester index width; must equal clog2(NUM_REQ).
TIMEOUT_CYCLES, 1040, RUN cycles allowed before abort; default is 2**(DATA_WIDTH*NUM_INPUTS)+16.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester operand-set valid.
req_ready  out  NUM_REQ  one-hot grant/accept; a transfer occurs when valid&ready.
req_data  in  NUM_REQ*NUM_INPUTS*DATA_WIDTH  operand sets; requester r occupies slice r, operand i in sub-slice i.
resp_valid  out  1  result available.
resp_ready  in  1  consumer accepts result.
resp_id  out  ID_W  requester that owns the result.
resp_data  out  NUM_INPUTS*DATA_WIDTH  product as captured from the multiplier.
resp_err  out  1  1 = run aborted by watchdog; resp_data is 0.
mul_rst  out  1  synchronous clear pulse to dsc_serial_mul rst.
mul_en  out  1  dsc_serial_mul en.
mul_data_in  out  NUM_INPUTS*DATA_WIDTH  operands to dsc_serial_mul bin_data_in, operand i in slice i.
mul_data_out  in  NUM_INPUTS*DATA_WIDTH  dsc_serial_mul bin_data_out.
mul_done  in  1  dsc_serial_mul done.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1) drives all outputs to 0:
  - req_ready, resp_valid, resp_id, resp_data, resp_err, mul_rst, mul_en, mul_data_in, busy.
  - State returns to IDLE, RR pointer to 0, watchdog counter to 0.
  - Reset mid-run abandons the operation; no response is produced.
- States:
  - IDLE: combinationally assert req_ready for exactly one requester: the first valid at or after the RR pointer, wrapping. None when no requester is valid. On transfer, latch operands into mul_data_in, latch the id, set RR pointer to id+1 mod NUM_REQ, and go to CLEAR.
  - CLEAR: mul_rst=1 and mul_en=0 for exactly one cycle, then go to RUN.
  - RUN: mul_en=1 and mul_data_in held stable; watchdog increments each cycle.
    - If mul_done=1: capture mul_data_out into resp_data, set resp_err=0, deassert mul_en, go to RESP.
    - Else if watchdog reaches TIMEOUT_CYCLES-1: set resp_data=0, resp_err=1, deassert mul_en, go to RESP.
    - If mul_done and the timeout coincide, done wins.
  - RESP: resp_valid=1 with resp_id/resp_data/resp_err held until resp_ready. On handshake, clear resp_valid, clear watchdog, and go to IDLE.
- Timing:
  - req_ready is 0 outside IDLE, so there is one outstanding operation.
  - Minimum re-arbitration: the cycle after the resp handshake.
- Latency: transfer at cycle T; CLEAR at T+1; first mul_en cycle at T+2. If mul_done is seen at cycle D, resp_valid is high from D+1.
- mul_done is sampled only in RUN; it is ignored in IDLE, CLEAR and RESP.
- A requester deasserting req_valid in IDLE before the transfer loses nothing. A grant is only a grant in a cycle where that requester's valid is high.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,3,0,...
- No arithmetic is performed on the data; widths are passed through unchanged.

Test Plan:
- Single request: stub multiplier asserts done 10 cycles after the first en, returning 10'd128. Requester 2 sends {5'd16,5'd8} -> mul_rst pulses at T+1, en high T+2..T+11, resp_valid at T+12 with id=2, data=128, err=0.
- All four requesters valid continuously with resp_ready=1 -> grant order 0,1,2,3,0 and resp_id follows the same order.
- Back-pressure: resp_ready held 0 for 20 cycles -> resp_valid and data stable throughout, req_ready all 0; next grant occurs the cycle after resp_ready=1.
- Timeout: stub never asserts done, with TIMEOUT_CYCLES=8 -> exactly 8 en cycles, then resp_err=1, resp_data=0; scheduler recovers and serves the next request normally.
- Async reset asserted mid-RUN, between clock edges -> outputs 0 immediately, no response emitted; the next request after release is granted from RR pointer 0.
- Integration with real dsc_serial_mul (DATA_WIDTH=5): operands 16 and 8 -> resp_data equals the multiplier's reference product for the same inputs, err=0, no timeout.
